// File: rtl/fetch_ctrl_pkg.sv
// Shared types and default sizing for the fetch pipeline controller.
package fetch_ctrl_pkg;

    localparam int IBUF_BUNDLES_DEF     = 8;
    localparam int REDIRECT_BUBBLES_DEF = 1;

    typedef enum logic [1:0] {
        INIT      = 2'd0,
        RUN       = 2'd1,
        MISS_WAIT = 2'd2,
        REDIRECT  = 2'd3
    } fetchCtrlState_t;

endpackage

// File: rtl/fetch_pipe_ctrl_if.sv
// Redirect, buffer, I-cache and control signals between the fetch front end and its controller.
interface fetch_pipe_ctrl_if #(
    parameter int CNT_W = $clog2(fetch_ctrl_pkg::IBUF_BUNDLES_DEF + 1)
);
    logic             exceptionFlag_i;
    logic             recoverFlag_i;
    logic             fs2RecoverFlag_i;
    logic             fs2Valid_i;
    logic             ibufPop_i;
    logic             icMiss_i;
    logic             icFillDone_i;
    logic             stall_o;
    logic             fs1Fs2Flush_o;
    logic             fetchEn_o;
    logic             missCancel_o;
    logic [CNT_W-1:0] credits_o;
    logic [1:0]       state_o;

    modport master (
        output exceptionFlag_i, recoverFlag_i, fs2RecoverFlag_i, fs2Valid_i,
               ibufPop_i, icMiss_i, icFillDone_i,
        input  stall_o, fs1Fs2Flush_o, fetchEn_o, missCancel_o, credits_o, state_o
    );

    modport slave (
        input  exceptionFlag_i, recoverFlag_i, fs2RecoverFlag_i, fs2Valid_i,
               ibufPop_i, icMiss_i, icFillDone_i,
        output stall_o, fs1Fs2Flush_o, fetchEn_o, missCancel_o, credits_o, state_o
    );
endinterface

// File: rtl/fetch_credit_cnt.sv
// Instruction-buffer free-slot counter: one push consumes a credit, one pop returns it.
module fetch_credit_cnt #(
    parameter int IBUF_BUNDLES = fetch_ctrl_pkg::IBUF_BUNDLES_DEF
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   push,
    input  logic                                   pop,
    input  logic                                   reload,
    output logic [$clog2(IBUF_BUNDLES + 1)-1:0]    credits
);
    localparam int               CNT_W = $clog2(IBUF_BUNDLES + 1);
    localparam logic [CNT_W-1:0] MAX   = CNT_W'(IBUF_BUNDLES);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] credits_nxt;

    // A full buffer flush returns every credit and discards same-cycle push/pop.
    always_comb begin
        credits_nxt = credits;
        if (reload) begin
            credits_nxt = MAX;
        end else if (push && !pop) begin
            credits_nxt = (credits == '0) ? '0 : credits - ONE;
        end else if (pop && !push) begin
            credits_nxt = (credits == MAX) ? MAX : credits + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credits <= MAX;
        end else begin
            credits <= credits_nxt;
            assert (!(push && !pop && !reload && credits == '0));
            assert (!(pop && !push && !reload && credits == MAX));
        end
    end
endmodule

// File: rtl/fetch_pipe_ctrl.sv
// Fetch1->Fetch2 sequencing: stall/flush/fetch-enable, redirect bubbles and I-cache miss waits.
module fetch_pipe_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int IBUF_BUNDLES     = IBUF_BUNDLES_DEF,
    parameter int REDIRECT_BUBBLES = REDIRECT_BUBBLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    fetch_pipe_ctrl_if.slave  bus
);
    localparam int         CNT_W   = $clog2(IBUF_BUNDLES + 1);
    localparam logic [1:0] BUBBLES = 2'(REDIRECT_BUBBLES);

    fetchCtrlState_t  state, state_nxt;
    logic [1:0]       bubble_cnt, bubble_nxt;
    logic [CNT_W-1:0] credits;
    logic             redirect, buf_flush, push;
    logic             stall, flush, fetch_en, miss_cancel;

    assign redirect  = bus.exceptionFlag_i | bus.recoverFlag_i | bus.fs2RecoverFlag_i;
    assign buf_flush = bus.exceptionFlag_i | bus.recoverFlag_i;
    assign push      = bus.fs2Valid_i & ~stall & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT;
            bubble_cnt <= '0;
        end else begin
            state      <= state_nxt;
            bubble_cnt <= bubble_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bubble_nxt  = bubble_cnt;
        stall       = 1'b0;
        flush       = 1'b0;
        fetch_en    = 1'b0;
        miss_cancel = 1'b0;
        case (state)
            INIT: state_nxt = RUN;
            RUN: begin
                stall    = (credits == '0) & bus.fs2Valid_i;
                fetch_en = ~stall;
                if (bus.icMiss_i) state_nxt = MISS_WAIT;
            end
            MISS_WAIT: begin
                stall       = 1'b1;
                miss_cancel = redirect;
                if (bus.icFillDone_i) state_nxt = RUN;
            end
            REDIRECT: begin
                if (bubble_cnt <= 2'd1) state_nxt = RUN;
                else                    bubble_nxt = bubble_cnt - 2'd1;
            end
            default: state_nxt = INIT;
        endcase
        // Any redirect outside INIT overrides the per-state transition above.
        if (state != INIT && redirect) begin
            flush      = 1'b1;
            state_nxt  = REDIRECT;
            bubble_nxt = BUBBLES;
        end
        if (reset) begin
            stall       = 1'b0;
            flush       = 1'b0;
            fetch_en    = 1'b0;
            miss_cancel = 1'b0;
        end
    end

    fetch_credit_cnt #(
        .IBUF_BUNDLES (IBUF_BUNDLES)
    ) u_credit_cnt (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (bus.ibufPop_i),
        .reload  (buf_flush),
        .credits (credits)
    );

    assign bus.stall_o       = stall;
    assign bus.fs1Fs2Flush_o = flush;
    assign bus.fetchEn_o     = fetch_en;
    assign bus.missCancel_o  = miss_cancel;
    assign bus.credits_o     = credits;
    assign bus.state_o       = state;
endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Bench for fetch_pipe_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_pipe_ctrl;
    localparam int IB    = 8;
    localparam int RB    = 1;
    localparam int CNT_W = $clog2(IB + 1);

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    fetch_pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    fetch_pipe_ctrl #(
        .IBUF_BUNDLES     (IB),
        .REDIRECT_BUBBLES (RB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: credits plus "what the front end is doing" (starting up, bubbles left, waiting on a miss).
    bit m_valid = 1'b0;
    bit m_init, m_miss;
    int m_bub, m_credits;
    int es, est, efe, efl, ecan, epush, redir;

    always @(negedge clk) begin
        if (reset) begin
            m_valid   = 1'b1;
            m_init    = 1'b1;
            m_miss    = 1'b0;
            m_bub     = 0;
            m_credits = IB;
        end else if (m_valid) begin
            if (m_init)         begin es = 0; est = 0; efe = 0; end
            else if (m_bub > 0) begin es = 3; est = 0; efe = 0; end
            else if (m_miss)    begin es = 2; est = 1; efe = 0; end
            else begin
                es  = 1;
                est = (m_credits == 0 && bus.fs2Valid_i) ? 1 : 0;
                efe = est ? 0 : 1;
            end
            redir = (bus.exceptionFlag_i | bus.recoverFlag_i | bus.fs2RecoverFlag_i) ? 1 : 0;
            efl   = (!m_init && redir) ? 1 : 0;
            ecan  = (efl && m_miss && m_bub == 0) ? 1 : 0;
            epush = (bus.fs2Valid_i && !est && !efl) ? 1 : 0;

            chk("state",   int'(bus.state_o),       es);
            chk("stall",   int'(bus.stall_o),       est);
            chk("fetchEn", int'(bus.fetchEn_o),     efe);
            chk("flush",   int'(bus.fs1Fs2Flush_o), efl);
            chk("cancel",  int'(bus.missCancel_o),  ecan);
            chk("credits", int'(bus.credits_o),     m_credits);

            if (bus.exceptionFlag_i || bus.recoverFlag_i) m_credits = IB;
            else m_credits = m_credits - epush + int'(bus.ibufPop_i);
            if (m_credits > IB) m_credits = IB;
            if (m_credits < 0)  m_credits = 0;

            if (m_init) m_init = 1'b0;
            else if (redir) begin m_bub = RB; m_miss = 1'b0; end
            else if (m_bub > 0) m_bub = m_bub - 1;
            else if (m_miss) begin if (bus.icFillDone_i) m_miss = 1'b0; end
            else if (bus.icMiss_i) m_miss = 1'b1;
        end
    end

    initial begin
        reset = 1'b1;
        bus.exceptionFlag_i  = 1'b0;
        bus.recoverFlag_i    = 1'b0;
        bus.fs2RecoverFlag_i = 1'b0;
        bus.fs2Valid_i       = 1'b0;
        bus.ibufPop_i        = 1'b0;
        bus.icMiss_i         = 1'b0;
        bus.icFillDone_i     = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("lit_init_state", int'(bus.state_o), 0);
        chk("lit_init_fe", int'(bus.fetchEn_o), 0);
        chk("lit_init_cred", int'(bus.credits_o), 8);
        tick(); #1;
        chk("lit_run_state", int'(bus.state_o), 1);
        chk("lit_run_fe", int'(bus.fetchEn_o), 1);

        // Fill the buffer with no pops.
        bus.fs2Valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("lit_fill_cred", int'(bus.credits_o), 8 - i);
            tick();
        end
        #1;
        chk("lit_full_cred", int'(bus.credits_o), 0);
        chk("lit_full_stall", int'(bus.stall_o), 1);
        bus.ibufPop_i = 1'b1;
        tick();
        bus.ibufPop_i = 1'b0;
        #1;
        chk("lit_unstall", int'(bus.stall_o), 0);
        tick(); #1;
        chk("lit_refill_cred", int'(bus.credits_o), 0);
        chk("lit_refill_stall", int'(bus.stall_o), 1);

        // Drain to 3 then run balanced push/pop.
        bus.fs2Valid_i = 1'b0;
        bus.ibufPop_i  = 1'b1;
        repeat (3) tick();
        bus.fs2Valid_i = 1'b1;
        repeat (4) begin
            #1;
            chk("lit_bal_cred", int'(bus.credits_o), 3);
            chk("lit_bal_stall", int'(bus.stall_o), 0);
            tick();
        end
        #1;
        chk("lit_bal_end", int'(bus.credits_o), 3);

        // Miss wait then fill.
        bus.fs2Valid_i = 1'b0;
        bus.ibufPop_i  = 1'b0;
        bus.icMiss_i   = 1'b1;
        tick();
        bus.icMiss_i = 1'b0;
        #1;
        chk("lit_miss_state", int'(bus.state_o), 2);
        chk("lit_miss_stall", int'(bus.stall_o), 1);
        chk("lit_miss_fe", int'(bus.fetchEn_o), 0);
        repeat (9) tick();
        bus.icFillDone_i = 1'b1;
        tick();
        bus.icFillDone_i = 1'b0;
        #1;
        chk("lit_fill_run", int'(bus.state_o), 1);

        // Recover during miss wait, fill arriving the same cycle.
        bus.icMiss_i = 1'b1;
        tick();
        bus.icMiss_i      = 1'b0;
        bus.recoverFlag_i = 1'b1;
        bus.icFillDone_i  = 1'b1;
        #1;
        chk("lit_rec_flush", int'(bus.fs1Fs2Flush_o), 1);
        chk("lit_rec_cancel", int'(bus.missCancel_o), 1);
        tick();
        bus.recoverFlag_i = 1'b0;
        bus.icFillDone_i  = 1'b0;
        #1;
        chk("lit_rec_state", int'(bus.state_o), 3);
        chk("lit_rec_cred", int'(bus.credits_o), 8);
        chk("lit_rec_fe0", int'(bus.fetchEn_o), 0);
        tick(); #1;
        chk("lit_rec_fe1", int'(bus.fetchEn_o), 1);

        // Exception together with Fetch2 recover at two credits.
        bus.fs2Valid_i = 1'b1;
        repeat (6) tick();
        bus.exceptionFlag_i  = 1'b1;
        bus.fs2RecoverFlag_i = 1'b1;
        #1;
        chk("lit_exc_cred", int'(bus.credits_o), 2);
        chk("lit_exc_flush", int'(bus.fs1Fs2Flush_o), 1);
        tick();
        bus.exceptionFlag_i  = 1'b0;
        bus.fs2RecoverFlag_i = 1'b0;
        bus.fs2Valid_i       = 1'b0;
        #1;
        chk("lit_exc_reload", int'(bus.credits_o), 8);
        chk("lit_exc_pulse", int'(bus.fs1Fs2Flush_o), 0);

        // Randomized traffic; inputs kept within what a real front end can produce.
        for (int n = 0; n < 3000; n++) begin
            tick();
            reset                = ($urandom_range(0, 299) == 0);
            bus.exceptionFlag_i  = ($urandom_range(0, 39) == 0);
            bus.recoverFlag_i    = ($urandom_range(0, 24) == 0);
            bus.fs2RecoverFlag_i = ($urandom_range(0, 19) == 0);
            bus.icMiss_i         = ($urandom_range(0, 7) == 0);
            bus.icFillDone_i     = ($urandom_range(0, 5) == 0);
            bus.ibufPop_i        = ($urandom_range(0, 2) == 0) && (m_credits < IB);
            bus.fs2Valid_i       = ($urandom_range(0, 3) != 0) && !(m_credits == 0 && m_bub > 0);
        end
        tick();
        reset = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_pipe_ctrl.md
Name: fetch_pipe_ctrl

Overview:
- Sequences the Fetch1->Fetch2 pipeline register and the fetch front end.
- Generates its stall and flush controls and the Fetch1 fetch enable.
- Tracks instruction-buffer credits and handles redirects: exception, backend recover, Fetch2 early recover.
- Handles I-cache miss waits with a small state machine.

Parameters:
- IBUF_BUNDLES, 8, instruction-buffer capacity in fetch bundles (>=2).
- REDIRECT_BUBBLES, 1, cycles fetchEn_o is held low after a redirect (1..3).
- CNT_W, $clog2(IBUF_BUNDLES+1), credit counter width (derived, not overridden).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- exceptionFlag_i  in  1  commit-time exception redirect
- recoverFlag_i  in  1  backend mispredict redirect; flushes instruction buffer same cycle
- fs2RecoverFlag_i  in  1  Fetch2 early redirect (BTB/RAS fix); instruction buffer not flushed
- fs2Valid_i  in  1  Fetch1Fetch2 register holds a valid bundle (fs1Ready_o of that register)
- ibufPop_i  in  1  one bundle freed from instruction buffer this cycle
- icMiss_i  in  1  Fetch1 I-cache access missed
- icFillDone_i  in  1  miss fill complete
- stall_o  out  1  stall to Fetch1Fetch2 register and Fetch1 PC
- fs1Fs2Flush_o  out  1  flush to Fetch1Fetch2 register
- fetchEn_o  out  1  Fetch1 may issue a PC/I-cache access
- missCancel_o  out  1  one-cycle pulse abandoning an outstanding miss
- credits_o  out  CNT_W  current free bundle credits (debug/perf)
- state_o  out  2  encoded FSM state (debug)

Behaviour:
- Reset (synchronous, active-high): state=INIT, credits=IBUF_BUNDLES, bubble counter=0, all 1-bit outputs 0. Reset overrides every other input the same cycle.
- FSM states: INIT=0, RUN=1, MISS_WAIT=2, REDIRECT=3.
- INIT: lasts exactly one cycle after reset deasserts, with fetchEn_o=0, then moves to RUN.
- Redirect priority: exceptionFlag_i > recoverFlag_i > fs2RecoverFlag_i. All three have the same effect on the FSM.
- Any redirect in RUN, MISS_WAIT or REDIRECT:
  - fs1Fs2Flush_o=1 combinationally that cycle.
  - next state=REDIRECT; bubble counter loads REDIRECT_BUBBLES.
  - A redirect in REDIRECT reloads the counter.
- REDIRECT: fetchEn_o=0 and stall_o=0; counter decrements each cycle; at counter==1 go to RUN.
- RUN:
  - fetchEn_o = ~stall_o.
  - If icMiss_i and no redirect, go to MISS_WAIT.
- MISS_WAIT:
  - fetchEn_o=0, stall_o=1.
  - icFillDone_i goes to RUN the next cycle.
  - A redirect in this state pulses missCancel_o=1 and goes to REDIRECT. This holds even if icFillDone_i arrives the same cycle; the redirect wins.
- Credits:
  - push = fs2Valid_i & ~stall_o & ~fs1Fs2Flush_o.
  - next = credits - push + ibufPop_i; simultaneous push and pop leaves credits unchanged.
  - exceptionFlag_i or recoverFlag_i: credits <= IBUF_BUNDLES, ignoring push/pop that cycle.
  - fs2RecoverFlag_i: push suppressed by the flush; pop still counted.
- stall_o in RUN = (credits==0) & fs2Valid_i. Purely combinational from registered state; no combinational path from ibufPop_i. A pop while credits==0 unstalls the following cycle.
- Boundaries:
  - Pop at credits==IBUF_BUNDLES: credits saturate; the simulation assertion fires.
  - Push at credits==0 is impossible by construction; assert it.
- Latency: redirect to first fetchEn_o=1 is REDIRECT_BUBBLES+1 cycles, counted from the redirect cycle.

Decomposition:
- fetch_ctrl_pkg holds:
  - the fetchCtrlState_t enum (INIT/RUN/MISS_WAIT/REDIRECT);
  - the default IBUF_BUNDLES and REDIRECT_BUBBLES constants.
- One natural sub-module: fetch_credit_cnt, holding the credit counter with saturation and assertions. The FSM stays in the top module.

Test Plan:
- Reset then idle, IBUF_BUNDLES=8 -> cycle 1 state=INIT, fetchEn_o=0; cycle 2 RUN, fetchEn_o=1, credits_o=8.
- fs2Valid_i=1 for 8 cycles, no pops -> credits_o 8..0; stall_o=1 on cycle 9. A pop then gives stall_o=0 next cycle and credits_o=0 after the resulting push.
- Simultaneous push and pop at credits_o=3 for 4 cycles -> credits_o stays 3; no stall.
- icMiss_i in RUN -> MISS_WAIT, stall_o=1, fetchEn_o=0. icFillDone_i 10 cycles later -> RUN the next cycle.
- recoverFlag_i during MISS_WAIT with icFillDone_i the same cycle -> fs1Fs2Flush_o=1, missCancel_o=1, state REDIRECT, credits_o=8. fetchEn_o=1 two cycles later (REDIRECT_BUBBLES=1).
- fs2RecoverFlag_i and exceptionFlag_i the same cycle, credits_o=2 -> credits reset to 8 (exception wins); single flush pulse.
